// File: rtl/riscv_debug_pkg.sv
// Shared definitions for the RISC-V debug trace path.
//
// Contents:
//   TRACE_SYNC_BYTE   - first byte of every trace frame
//   TRACE_FRAME_BYTES - number of bytes per frame (sync + 4 pc + 4 next_pc)
//   tx_state_e        - UART transmitter state encoding
//   trace_frame_byte  - selects the byte to transmit for a given byte index
package riscv_debug_pkg;

  localparam logic [7:0] TRACE_SYNC_BYTE   = 8'hA5;
  localparam int         TRACE_FRAME_BYTES = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  // Byte 0 is the sync byte; byte k (1..8) is frame[71-8k -: 8], i.e. the
  // 64-bit {pc, next_pc} word sent most-significant byte first.
  function automatic logic [7:0] trace_frame_byte(input logic [63:0] frame,
                                                  input logic [3:0]  idx);
    logic [7:0]  b;
    logic [5:0]  shamt;
    logic [63:0] shifted;
    b       = TRACE_SYNC_BYTE;
    shamt   = {3'(4'd8 - idx), 3'b000};
    shifted = frame >> shamt;
    if ((idx != 4'd0) && (idx <= 4'd8)) begin
      b = shifted[7:0];
    end
    return b;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO for trace entries.
//
// Ports:
//   clk, reset  - clock and asynchronous active-high reset
//   push, din   - write request and data
//   pop, dout   - read request and head-of-queue data (valid when !empty)
//   full, empty - occupancy flags
//   count       - current occupancy, 0..DEPTH
//
// A push while full is still accepted when a pop happens on the same edge,
// because the pop frees the slot the push lands in.
module trace_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read when count says valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/pc_trace_tx.sv
// PC trace transmitter: captures control-flow events from the core's
// PC-update path and sends them as 9-byte frames on an 8N1 UART line.
//
// Ports:
//   clk, reset    - clock and asynchronous active-high reset
//   commit_valid  - an instruction retires this cycle
//   pc, next_pc   - PC of the retiring instruction and its selected next PC
//   jump_taken    - next_pc is not pc+4
//   clear_ovf     - pulse that clears the sticky overflow flag
//   tx            - UART line, idle high, LSB first
//   busy          - a frame is being shifted out
//   overflow      - at least one event was dropped since the last clear
//   fifo_count    - current trace FIFO occupancy
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | line high; pops the FIFO head into the frame register if any
// START | start bit (low) of byte byte_idx
// DATA  | data bit bit_idx of byte byte_idx
// STOP  | stop bit (high); next byte or back to IDLE after byte 8
module pc_trace_tx
  import riscv_debug_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH        = 8,
  parameter int TRACE_ALL    = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     commit_valid,
  input  logic [31:0]              pc,
  input  logic [31:0]              next_pc,
  input  logic                     jump_taken,
  input  logic                     clear_ovf,
  output logic                     tx,
  output logic                     busy,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    BYTE_LAST = 4'(TRACE_FRAME_BYTES - 1);

  tx_state_e     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [3:0]    byte_q, byte_d;
  logic [63:0]   frame_q, frame_d;
  logic          tx_q, tx_d;
  logic          ovf_q, ovf_d;

  logic          capture;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [63:0]   fifo_dout;
  logic          bit_end;
  logic [7:0]    next_byte;

  assign capture = commit_valid && (jump_taken || (TRACE_ALL != 0));
  assign pop     = (state_q == IDLE) && !fifo_empty;
  assign bit_end = (baud_q == BAUD_LAST);

  trace_fifo #(
    .WIDTH (64),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (capture),
    .din   ({pc, next_pc}),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Set has priority over clear so a drop is never lost.
  always_comb begin
    ovf_d = ovf_q;
    if (clear_ovf) begin
      ovf_d = 1'b0;
    end
    if (capture && fifo_full && !pop) begin
      ovf_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    frame_d = frame_q;

    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          frame_d = fifo_dout;
          byte_d  = '0;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_d = '0;
          if (byte_q < BYTE_LAST) begin
            byte_d  = byte_q + 1'b1;
            state_d = START;
          end else begin
            byte_d  = '0;
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
        bit_d   = '0;
        byte_d  = '0;
      end
    endcase
  end

  // The line level is derived from the next state and registered, so tx
  // changes on the same edge as the state and never glitches.
  always_comb begin
    next_byte = trace_frame_byte(frame_d, byte_d);
    tx_d      = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = next_byte[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      frame_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      frame_q <= frame_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = (state_q != IDLE);
  assign overflow = ovf_q;

endmodule

// File: tb/tb_pc_trace_tx.sv
module tb_pc_trace_tx;

  localparam int CPB   = 4;
  localparam int FLEN  = 90 * CPB;
  localparam int FSTEP = FLEN + 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        cv0, cv1;
  logic [31:0] pc, next_pc;
  logic        jump_taken;
  logic        clear_ovf;

  logic        tx0, busy0, ovf0;
  logic [3:0]  cnt0;
  logic        tx1, busy1, ovf1;
  logic [3:0]  cnt1;

  int n_checks = 0;
  int n_fail   = 0;

  logic tx_log   [0:4095];
  logic busy_log [0:4095];

  always #5 clk = ~clk;

  pc_trace_tx #(.CLKS_PER_BIT(CPB), .DEPTH(8), .TRACE_ALL(0)) dut0 (
    .clk(clk), .reset(reset), .commit_valid(cv0), .pc(pc), .next_pc(next_pc),
    .jump_taken(jump_taken), .clear_ovf(clear_ovf), .tx(tx0), .busy(busy0),
    .overflow(ovf0), .fifo_count(cnt0)
  );

  pc_trace_tx #(.CLKS_PER_BIT(CPB), .DEPTH(8), .TRACE_ALL(1)) dut1 (
    .clk(clk), .reset(reset), .commit_valid(cv1), .pc(pc), .next_pc(next_pc),
    .jump_taken(jump_taken), .clear_ovf(clear_ovf), .tx(tx1), .busy(busy1),
    .overflow(ovf1), .fifo_count(cnt1)
  );

  // Samples n cycles starting now (a point #1 after a rising edge).
  task automatic record(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      tx_log[i]   = (d == 0) ? tx0 : tx1;
      busy_log[i] = (d == 0) ? busy0 : busy1;
      @(posedge clk); #1;
    end
  endtask

  // Mid-bit decode of a 9-byte frame whose start bit begins at log index base.
  function automatic logic [71:0] decode(input int base);
    logic [71:0] r;
    r = '0;
    for (int k = 0; k < 9; k++)
      for (int j = 0; j < 8; j++)
        r[64 - 8*k + j] = tx_log[base + k*10*CPB + (1+j)*CPB + CPB/2];
    return r;
  endfunction

  function automatic logic framing_ok(input int base);
    logic ok;
    ok = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (tx_log[base + k*10*CPB + CPB/2] !== 1'b0) ok = 1'b0;
      if (tx_log[base + k*10*CPB + 9*CPB + CPB/2] !== 1'b1) ok = 1'b0;
    end
    return ok;
  endfunction

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (tx0 !== 1'b1) begin n_fail++; $display("FAIL reset_tx got=%b exp=1", tx0); end
    n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy0); end
    n_checks++; if (ovf0 !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", ovf0); end
    n_checks++; if (cnt0 !== 4'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", cnt0); end
    n_checks++; if ({tx1, busy1, ovf1, cnt1} !== {1'b1, 1'b0, 1'b0, 4'd0})
      begin n_fail++; $display("FAIL reset_dut1 got=%b%b%b%0d exp=1000", tx1, busy1, ovf1, cnt1); end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (tx0 !== 1'b1) begin n_fail++; $display("FAIL post_reset_tx got=%b exp=1", tx0); end
  endtask

  task automatic test_single_jump;
    logic [71:0] exp;
    logic        all_busy;
    exp = {8'hA5, 32'h0000_0010, 32'h0000_0040};
    @(negedge clk); cv0 = 1'b1; jump_taken = 1'b1; pc = 32'h10; next_pc = 32'h40;
    @(posedge clk); #1;
    n_checks++; if (cnt0 !== 4'd1) begin n_fail++; $display("FAIL single_count_E0 got=%0d exp=1", cnt0); end
    n_checks++; if (tx0 !== 1'b1) begin n_fail++; $display("FAIL single_tx_E0 got=%b exp=1", tx0); end
    @(negedge clk); cv0 = 1'b0; jump_taken = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (tx0 !== 1'b0) begin n_fail++; $display("FAIL single_tx_E1 got=%b exp=0", tx0); end
    n_checks++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL single_busy_E1 got=%b exp=1", busy0); end
    n_checks++; if (cnt0 !== 4'd0) begin n_fail++; $display("FAIL single_count_E1 got=%0d exp=0", cnt0); end
    record(0, FSTEP);
    n_checks++; if (decode(0) !== exp) begin n_fail++; $display("FAIL single_frame got=%h exp=%h", decode(0), exp); end
    n_checks++; if (framing_ok(0) !== 1'b1) begin n_fail++; $display("FAIL single_framing got=0 exp=1"); end
    all_busy = 1'b1;
    for (int i = 0; i < FLEN; i++) if (busy_log[i] !== 1'b1) all_busy = 1'b0;
    n_checks++; if (all_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_span got=0 exp=1"); end
    n_checks++; if (busy_log[FLEN] !== 1'b0) begin n_fail++; $display("FAIL single_busy_end got=%b exp=0", busy_log[FLEN]); end
    n_checks++; if (tx_log[FLEN] !== 1'b1) begin n_fail++; $display("FAIL single_tx_end got=%b exp=1", tx_log[FLEN]); end
  endtask

  task automatic test_trace_filter;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); cv0 = 1'b1; jump_taken = 1'b0; pc = 32'h100 + 32'(4*i); next_pc = pc + 32'd4;
      @(posedge clk); #1;
      n_checks++; if (cnt0 !== 4'd0) begin n_fail++; $display("FAIL filter_count i=%0d got=%0d exp=0", i, cnt0); end
      n_checks++; if (tx0 !== 1'b1) begin n_fail++; $display("FAIL filter_tx i=%0d got=%b exp=1", i, tx0); end
    end
    @(negedge clk); cv0 = 1'b0;
  endtask

  task automatic test_trace_all;
    logic [31:0] ep, en;
    for (int i = 0; i < 20; i++) begin
      ep = 32'h0000_1000 + 32'(4*i);
      en = ep + 32'd4;
      @(negedge clk); cv1 = 1'b1; jump_taken = 1'b0; pc = ep; next_pc = en;
      @(posedge clk); #1;
      n_checks++; if (cnt1 !== 4'd1) begin n_fail++; $display("FAIL all_count i=%0d got=%0d exp=1", i, cnt1); end
      @(negedge clk); cv1 = 1'b0;
      @(posedge clk); #1;
      record(1, FSTEP);
      n_checks++; if (decode(0) !== {8'hA5, ep, en})
        begin n_fail++; $display("FAIL all_frame i=%0d got=%h exp=%h", i, decode(0), {8'hA5, ep, en}); end
      n_checks++; if (busy_log[FLEN] !== 1'b0) begin n_fail++; $display("FAIL all_busy_end i=%0d got=%b exp=0", i, busy_log[FLEN]); end
    end
  endtask

  task automatic test_overflow;
    logic [71:0] exp;
    @(negedge clk); cv0 = 1'b1; jump_taken = 1'b1; pc = 32'h2000; next_pc = 32'h3000;
    @(posedge clk); #1;
    @(negedge clk); pc = 32'h2010; next_pc = 32'h3001;
    @(posedge clk); #1;
    n_checks++; if (cnt0 !== 4'd1) begin n_fail++; $display("FAIL ovf_count_E1 got=%0d exp=1", cnt0); end
    fork
      record(0, 9*FSTEP + 1);
      begin
        for (int i = 2; i < 10; i++) begin
          @(negedge clk);
          pc = 32'h2000 + 32'(16*i); next_pc = 32'h3000 + 32'(i);
          if (i == 9) clear_ovf = 1'b1;
          @(posedge clk); #1;
          if (i == 8) begin
            n_checks++; if (cnt0 !== 4'd8) begin n_fail++; $display("FAIL ovf_count_E8 got=%0d exp=8", cnt0); end
            n_checks++; if (ovf0 !== 1'b0) begin n_fail++; $display("FAIL ovf_flag_E8 got=%b exp=0", ovf0); end
          end
          if (i == 9) begin
            n_checks++; if (ovf0 !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins got=%b exp=1", ovf0); end
            n_checks++; if (cnt0 !== 4'd8) begin n_fail++; $display("FAIL ovf_count_E9 got=%0d exp=8", cnt0); end
          end
        end
        @(negedge clk); cv0 = 1'b0; jump_taken = 1'b0; clear_ovf = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (ovf0 !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got=%b exp=1", ovf0); end
        @(negedge clk); clear_ovf = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (ovf0 !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got=%b exp=0", ovf0); end
        @(negedge clk); clear_ovf = 1'b0;
      end
    join
    for (int j = 0; j < 9; j++) begin
      exp = {8'hA5, 32'h2000 + 32'(16*j), 32'h3000 + 32'(j)};
      n_checks++; if (decode(j*FSTEP) !== exp) begin n_fail++; $display("FAIL ovf_frame j=%0d got=%h exp=%h", j, decode(j*FSTEP), exp); end
      n_checks++; if (framing_ok(j*FSTEP) !== 1'b1) begin n_fail++; $display("FAIL ovf_framing j=%0d got=0 exp=1", j); end
    end
    n_checks++; if ({busy_log[9*FSTEP], tx_log[9*FSTEP]} !== 2'b01)
      begin n_fail++; $display("FAIL ovf_no_tenth got=%b%b exp=01", busy_log[9*FSTEP], tx_log[9*FSTEP]); end
    n_checks++; if (cnt0 !== 4'd0) begin n_fail++; $display("FAIL ovf_count_end got=%0d exp=0", cnt0); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk); cv0 = 1'b1; jump_taken = 1'b1; pc = 32'hDEAD_BEEF; next_pc = 32'h0000_0100;
    @(posedge clk); #1;
    @(negedge clk); pc = 32'h1234_5678; next_pc = 32'h8765_4320;
    @(posedge clk); #1;
    n_checks++; if (cnt0 !== 4'd1) begin n_fail++; $display("FAIL b2b_count got=%0d exp=1", cnt0); end
    fork
      record(0, 2*FSTEP + 1);
      begin
        @(negedge clk); cv0 = 1'b0; jump_taken = 1'b0;
      end
    join
    n_checks++; if (decode(0) !== {8'hA5, 32'hDEAD_BEEF, 32'h0000_0100})
      begin n_fail++; $display("FAIL b2b_frame0 got=%h exp=%h", decode(0), {8'hA5, 32'hDEAD_BEEF, 32'h0000_0100}); end
    n_checks++; if (decode(FSTEP) !== {8'hA5, 32'h1234_5678, 32'h8765_4320})
      begin n_fail++; $display("FAIL b2b_frame1 got=%h exp=%h", decode(FSTEP), {8'hA5, 32'h1234_5678, 32'h8765_4320}); end
    n_checks++; if ({tx_log[FLEN-1], tx_log[FLEN], tx_log[FLEN+1]} !== 3'b110)
      begin n_fail++; $display("FAIL b2b_gap_tx got=%b%b%b exp=110", tx_log[FLEN-1], tx_log[FLEN], tx_log[FLEN+1]); end
    n_checks++; if ({busy_log[FLEN], busy_log[FLEN+1]} !== 2'b01)
      begin n_fail++; $display("FAIL b2b_gap_busy got=%b%b exp=01", busy_log[FLEN], busy_log[FLEN+1]); end
  endtask

  task automatic test_reset_mid_frame;
    logic quiet;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); cv0 = 1'b1; jump_taken = 1'b1; pc = 32'h4000 + 32'(4*i); next_pc = 32'h5000;
      @(posedge clk); #1;
    end
    n_checks++; if (cnt0 !== 4'd3) begin n_fail++; $display("FAIL rst_count_before got=%0d exp=3", cnt0); end
    @(negedge clk); cv0 = 1'b0; jump_taken = 1'b0;
    repeat (137) @(posedge clk);
    #2;
    n_checks++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL rst_busy_before got=%b exp=1", busy0); end
    reset = 1'b1;
    #1;
    n_checks++; if (tx0 !== 1'b1) begin n_fail++; $display("FAIL rst_async_tx got=%b exp=1", tx0); end
    n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL rst_async_busy got=%b exp=0", busy0); end
    n_checks++; if (cnt0 !== 4'd0) begin n_fail++; $display("FAIL rst_async_count got=%0d exp=0", cnt0); end
    @(negedge clk); reset = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (tx0 !== 1'b1 || busy0 !== 1'b0) quiet = 1'b0;
    end
    n_checks++; if (quiet !== 1'b1) begin n_fail++; $display("FAIL rst_no_frame got=0 exp=1"); end
    n_checks++; if (cnt0 !== 4'd0) begin n_fail++; $display("FAIL rst_count_after got=%0d exp=0", cnt0); end
  endtask

  initial begin
    reset = 1'b1; cv0 = 1'b0; cv1 = 1'b0; pc = '0; next_pc = '0;
    jump_taken = 1'b0; clear_ovf = 1'b0;
    test_reset();
    test_single_jump();
    test_trace_filter();
    test_trace_all();
    test_overflow();
    test_back_to_back();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pc_trace_tx.md
# pc_trace_tx

Debug trace transmitter for the RISC-V core. It captures control-flow events (PC and next-PC on taken jumps/branches, or on every instruction) from the core's PC-update path, buffers them, and sends them out as framed bytes on a UART serial line. Bench scripts and lab tools can therefore follow program flow without probing internal signals. It sits beside the core, taps the PC/next-PC/jump signals, and drives one output pin.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per UART bit; legal values ≥ 2.
- `DEPTH`, 8: trace FIFO entries; power of 2, ≥ 2.
- `TRACE_ALL`, 0: 0 captures only commits with `jump_taken`=1; 1 captures every commit.
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `commit_valid`  in  1  an instruction retires this cycle.
- `pc`  in  32  PC of the retiring instruction.
- `next_pc`  in  32  selected next PC, either PC+4 or PC+imm.
- `jump_taken`  in  1  next PC is not PC+4 (branch or jump taken).
- `clear_ovf`  in  1  one-cycle pulse that clears `overflow`.
- `tx`  out  1  UART line, 8N1, LSB first, idle high.
- `busy`  out  1  a frame is being shifted out (state ≠ IDLE).
- `overflow`  out  1  sticky flag: at least one event was dropped.
- `fifo_count`  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- Capture condition: `commit_valid` && (`jump_taken` || `TRACE_ALL`). On a capture edge, {pc, next_pc} (64 bits) is pushed into the FIFO.
- Push while full:
  - Accepted if the TX FSM pops on the same edge.
  - Otherwise the entry is dropped and `overflow` is set.
- `overflow` is cleared by `clear_ovf`. If a set and a clear occur on the same edge, the set wins.
- Frame format, 9 bytes: sync 0xA5, then pc[31:24], pc[23:16], pc[15:8], pc[7:0], then next_pc bytes MSB first.
- Each byte is sent as start(0), d0..d7, stop(1). Every bit lasts `CLKS_PER_BIT` cycles.
- FSM states:
  - IDLE: `tx`=1. If FIFO is non-empty, pop the head into a 64-bit frame register, set byte_idx=0, go to START.
  - START: `tx`=0 for one bit time, then go to DATA with bit_idx=0.
  - DATA: `tx`=current byte[bit_idx] for one bit time each. After bit 7, go to STOP.
  - STOP: `tx`=1 for one bit time. If byte_idx<8, increment it and go to START with no idle gap. Otherwise go to IDLE.
- Byte select: byte_idx 0 is 0xA5. byte_idx k (1..8) is frame_reg[71-8k -: 8].
- Counters:
  - baud counter 0..CLKS_PER_BIT-1; a bit ends when it reaches CLKS_PER_BIT-1.
  - bit_idx 0..7; byte_idx 0..8.
  - None of them wrap outside these ranges.
- Reset values: `tx`=1, `busy`=0, `overflow`=0, `fifo_count`=0. FSM=IDLE, FIFO empty, all counters 0.
- Reset mid-frame aborts the frame immediately; `tx` returns high asynchronously. Buffered entries are lost.

## Timing
- Capture at edge E0. The entry is visible in `fifo_count` after E0.
- At E1, IDLE pops the entry and START begins, so `tx` falls at E1.
- Frame length: 90×`CLKS_PER_BIT` cycles from E1. `tx` is high at the final STOP edge.
- Back-to-back frames are separated by exactly one IDLE cycle of `tx`=1.
- `busy` rises at E1 and falls at the edge where the FSM enters IDLE.
- Pop occurs only on the IDLE→START edge. `fifo_count` updates on the same edge as a push or pop; a simultaneous push and pop leaves it unchanged.

## Structure
- Package `riscv_debug_pkg` holds:
  - `TRACE_SYNC_BYTE` = 8'hA5
  - `TRACE_FRAME_BYTES` = 9
  - the TX state encoding (IDLE, START, DATA, STOP)
- Sub-module `trace_fifo`: synchronous FIFO with parameters WIDTH=64 and DEPTH, ports push/pop/full/empty/count, and the same clock and reset. Push-when-full-with-pop is accepted.
- The top level holds the capture logic, overflow flag, and TX FSM.

## Test plan
- Single jump (`CLKS_PER_BIT`=4), pc=0x00000010, next_pc=0x00000040 → `tx` decodes to A5 00 00 00 10 00 00 00 40. `tx` falls 1 cycle after capture; frame lasts 360 cycles; `busy` high throughout.
- `TRACE_ALL`=0, 20 commits with `jump_taken`=0 → `fifo_count` stays 0 and `tx` stays high. Repeat with `TRACE_ALL`=1 → 20 frames with incrementing pc.
- Overflow (`DEPTH`=8): 10 consecutive capture cycles starting at E0 → capture 10 (E9) is dropped, `overflow`=1 after E9, exactly 9 frames are sent in order.
- `clear_ovf` asserted on the same edge as an overflowing push → `overflow` stays 1. `clear_ovf` alone one cycle later → 0.
- Reset asserted mid-DATA of byte 3 with 3 entries queued → `tx`=1 and `busy`=0 without waiting for a clock edge; `fifo_count`=0; after release no frame is emitted.
- Two captures 1 cycle apart → two contiguous frames with a single-cycle idle-high gap; the second frame's sync byte starts 90×`CLKS_PER_BIT`+1 cycles after the first start bit.
